jtag_dmi_client: RTL and testbench
==================================

JTAG_DMI_CLIENT -- requirements
Module: jtag_dmi_client

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h0000_0001, meaning value captured for IR 0x01.
REQ-002 SHALL have parameter ABITS, default 16, meaning DMI address width (DR = ABITS+34 = 50 bits).
REQ-003 jtag_tck  in  1  TAP clock; all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ir  in  5  instruction register from TAP.
REQ-006 dr_action  in  2  0 none, 1 capture, 2 shift, 3 update.
REQ-007 dr_in  in  50  TAP shift-register contents.
REQ-008 dr_out  out  50  capture value, or next shift value, to the TAP.
REQ-009 dr_tdi_mask  out  50  one-hot TDI insertion bit, at (DR length - 1).
REQ-010 dmi_req_valid / dmi_req_ready  out / in  1 / 1  DM request handshake.
REQ-011 dmi_req_op, dmi_req_addr, dmi_req_data  out  2, 16, 32  op 1 read, 2 write; address; write data.
REQ-012 dmi_rsp_valid  in  1  DM response strobe.
REQ-013 dmi_rsp_data, dmi_rsp_err  in  32, 1  read data; error flag.

Function
REQ-014 IR decode: 0x01 IDCODE (32b), 0x10 DTMCS (32b), 0x11 DMI (50b), others BYPASS (1b).
REQ-015 dr_tdi_mask SHALL be a combinational decode of ir: bit 31, bit 31, bit 49, bit 0 respectively.
REQ-016 Capture (action 1): dr_out = zero-extended register for the current IR; BYPASS gives 0.
REQ-017 Shift (action 2): dr_out = dr_in >> 1, with only bits below the DR length kept; the TAP inserts TDI.
REQ-018 Actions 0 and 3: dr_out = dr_in.
REQ-019 DTMCS capture: [3:0]=1, [9:4]=ABITS, [11:10]=dmistat, [14:12]=1, all other bits 0.
REQ-020 DMI capture: {last_addr[15:0], rsp_data[31:0], status[1:0]}; status = 3 if busy, else sticky dmistat.
REQ-021 dmistat codes: 0 ok, 2 failed, 3 busy; dmistat is sticky; a nonzero value is never overwritten by 0 except by dmireset.
REQ-022 FSM states: IDLE, REQ, WAIT.
REQ-023 IDLE->REQ on DMI update with op in {1,2} and dmistat==0; latch addr=dr_in[49:34], data=dr_in[33:2], op=dr_in[1:0].
REQ-024 In REQ, dmi_req_valid=1; payload SHALL be stable until dmi_req_ready; ready -> WAIT.
REQ-025 WAIT->IDLE on dmi_rsp_valid; rsp_data latched; dmi_rsp_err sets dmistat=2.
REQ-026 DMI update while in REQ/WAIT: no new request; dmistat=3.
REQ-027 DMI update with op 0, or with dmistat!=0: no request; state unchanged.
REQ-028 DTMCS update, bit16 (dmireset): dmistat=0.
REQ-029 DTMCS update, bit17 (dmihardreset): dmistat=0; FSM->IDLE, abandoning any transaction; a later dmi_rsp_valid is ignored.
REQ-030 If dmihardreset and dmi_req_ready occur in the same cycle, hardreset wins; no response is awaited.
REQ-031 dmi_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-032 IDCODE and BYPASS updates SHALL have no effect.

Reset
REQ-033 On reset_n low: FSM=IDLE, dmi_req_valid=0, dmi_req_op/addr/data=0, last_addr=0, rsp_data=0, dmistat=0.
REQ-034 Reset mid-transaction SHALL drop it silently.

Structure
REQ-035 A shared package jtag_pkg SHALL hold the dr_action encoding, IR codes, dmistat codes and DMI op codes.
REQ-036 A single sub-module, jtag_dmi_req_fsm, SHALL hold the REQ/WAIT handshake FSM; IR decode and DR muxing stay at top level.

Verification
REQ-037 IR=0x01, capture -> dr_out=IDCODE; dr_tdi_mask bit 31 set.
REQ-038 IR=0x11, update dr_in={16'h0010,32'hDEADBEEF,2'd2}, ready=1 -> one request cycle with op=2, addr=0x10, data=0xDEADBEEF.
REQ-039 Read addr 0x11, response 0x12345678 -> next DMI capture = {16'h0011,32'h12345678,2'd0}.
REQ-040 Second DMI update while WAIT -> capture status=3; DTMCS update 0x10000 -> status 0.
REQ-041 dmi_rsp_err=1 -> DTMCS capture [11:10]=2; next DMI write issues no request.
REQ-042 Shift on IR=0x1F with dr_in=1 -> dr_out=0; reset_n low during REQ -> dmi_req_valid=0 immediately.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG/DMI encodings: DR actions, IR codes, dmistat codes, DMI ops,
// the DR selection derived from IR, and the request FSM states.
package jtag_pkg;

  typedef enum logic [1:0] {
    DR_NONE    = 2'd0,
    DR_CAPTURE = 2'd1,
    DR_SHIFT   = 2'd2,
    DR_UPDATE  = 2'd3
  } dr_action_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_DTMCS,
    SEL_DMI
  } dr_sel_e;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_REQ,
    FSM_WAIT
  } dmi_fsm_e;

  // Any instruction that is not one of ours falls back to the 1-bit bypass DR.
  function automatic dr_sel_e decode_ir(input logic [4:0] ir);
    case (ir)
      IR_IDCODE: return SEL_IDCODE;
      IR_DTMCS:  return SEL_DTMCS;
      IR_DMI:    return SEL_DMI;
      default:   return SEL_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_dmi_req_fsm.sv
// DMI request/response handshake: holds the request payload stable while
// valid is up, then waits for the debug module's response strobe.
module jtag_dmi_req_fsm
  import jtag_pkg::*;
#(
  parameter int ABITS = 16
) (
  input  logic             jtag_tck,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       start_op,
  input  logic [ABITS-1:0] start_addr,
  input  logic [31:0]      start_data,
  input  logic             abort,
  input  logic             req_ready,
  input  logic             rsp_valid,
  output logic             req_valid,
  output logic [1:0]       req_op,
  output logic [ABITS-1:0] req_addr,
  output logic [31:0]      req_data,
  output logic             busy,
  output logic             rsp_done
);

  dmi_fsm_e state_q, state_d;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge jtag_tck or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state_q <= FSM_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort (hard reset) outranks both ready and response.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_d  = state_q;
    rsp_done = 1'b0;
    case (state_q)
      FSM_IDLE: if (start) state_d = FSM_REQ;
      FSM_REQ: begin
        if (abort)          state_d = FSM_IDLE;
        else if (req_ready) state_d = FSM_WAIT;
      end
      FSM_WAIT: begin
        if (abort) begin
          state_d = FSM_IDLE;
        end else if (rsp_valid) begin
          state_d  = FSM_IDLE;
          rsp_done = 1'b1;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  // Payload is captured only when a request starts, so it cannot move
  // while valid waits for ready.
  always_ff @(posedge jtag_tck or negedge reset_n) begin
    if (!reset_n) begin
      req_op   <= DMI_OP_NOP;
      req_addr <= '0;
      req_data <= '0;
    end else if (start) begin
      req_op   <= start_op;
      req_addr <= start_addr;
      req_data <= start_data;
    end
  end

  assign req_valid = (state_q == FSM_REQ);
  assign busy      = (state_q != FSM_IDLE);

endmodule

// File: rtl/jtag_dmi_client.sv
// JTAG DTM data-register side: IR decode, capture/shift muxing for IDCODE,
// DTMCS, DMI and BYPASS, plus the sticky dmistat and response data.
module jtag_dmi_client
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE = 32'h0000_0001,
  parameter int          ABITS  = 16
) (
  input  logic              jtag_tck,
  input  logic              reset_n,
  input  logic [4:0]        ir,
  input  logic [1:0]        dr_action,
  input  logic [ABITS+33:0] dr_in,
  output logic [ABITS+33:0] dr_out,
  output logic [ABITS+33:0] dr_tdi_mask,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [1:0]        dmi_req_op,
  output logic [ABITS-1:0]  dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  input  logic              dmi_rsp_valid,
  input  logic [31:0]       dmi_rsp_data,
  input  logic              dmi_rsp_err
);

  localparam int DRW = ABITS + 34;

  dr_sel_e          sel;
  dr_action_e       action;
  logic [DRW-1:0]   len_mask;
  logic [DRW-1:0]   capture_value;
  logic [31:0]      dtmcs_value;
  logic [1:0]       dmistat;
  logic [1:0]       dmi_status;
  logic [31:0]      rsp_data;
  logic             busy;
  logic             rsp_done;
  logic             dmi_update;
  logic             dtmcs_update;
  logic             dmireset;
  logic             hardreset;
  logic             op_ok;
  logic             start;
  logic             busy_hit;

  assign sel    = decode_ir(ir);
  assign action = dr_action_e'(dr_action);

  // TDI enters at the top bit of the selected register.
  always_comb begin
    dr_tdi_mask = '0;
    case (sel)
      SEL_IDCODE: dr_tdi_mask[31]    = 1'b1;
      SEL_DTMCS:  dr_tdi_mask[31]    = 1'b1;
      SEL_DMI:    dr_tdi_mask[DRW-1] = 1'b1;
      default:    dr_tdi_mask[0]     = 1'b1;
    endcase
  end

  // All ones below the register length; wraps to all ones for the full DMI DR.
  assign len_mask = (dr_tdi_mask << 1) - DRW'(1);

  assign dtmcs_value = {17'd0, 3'd1, dmistat, 6'(ABITS), 4'd1};
  assign dmi_status  = busy ? DMISTAT_BUSY : dmistat;

  // Capture value of the selected register, zero-extended to the DR width.
  always_comb begin
    capture_value = '0;
    case (sel)
      SEL_IDCODE: capture_value = DRW'(IDCODE);
      SEL_DTMCS:  capture_value = DRW'(dtmcs_value);
      SEL_DMI:    capture_value = {dmi_req_addr, rsp_data, dmi_status};
      default:    ;
    endcase
  end

  // Value returned to the TAP for the current DR action.
  always_comb begin
    dr_out = dr_in;
    case (action)
      DR_CAPTURE: dr_out = capture_value;
      DR_SHIFT:   dr_out = (dr_in >> 1) & len_mask;
      default:    ;
    endcase
  end

  assign dmi_update   = (action == DR_UPDATE) && (sel == SEL_DMI);
  assign dtmcs_update = (action == DR_UPDATE) && (sel == SEL_DTMCS);
  assign dmireset     = dtmcs_update && dr_in[16];
  assign hardreset    = dtmcs_update && dr_in[17];
  assign op_ok        = (dr_in[1:0] == DMI_OP_READ) || (dr_in[1:0] == DMI_OP_WRITE);
  assign start        = dmi_update && !busy && op_ok && (dmistat == DMISTAT_OK);
  assign busy_hit     = dmi_update && busy;

  jtag_dmi_req_fsm #(.ABITS(ABITS)) u_req_fsm (
    .jtag_tck   (jtag_tck),
    .reset_n    (reset_n),
    .start      (start),
    .start_op   (dr_in[1:0]),
    .start_addr (dr_in[DRW-1 -: ABITS]),
    .start_data (dr_in[33:2]),
    .abort      (hardreset),
    .req_ready  (dmi_req_ready),
    .rsp_valid  (dmi_rsp_valid),
    .req_valid  (dmi_req_valid),
    .req_op     (dmi_req_op),
    .req_addr   (dmi_req_addr),
    .req_data   (dmi_req_data),
    .busy       (busy),
    .rsp_done   (rsp_done)
  );

  // Sticky dmistat and latched response data; only DTMCS resets clear status.
  always_ff @(posedge jtag_tck or negedge reset_n) begin
    if (!reset_n) begin
      dmistat  <= DMISTAT_OK;
      rsp_data <= '0;
    end else begin
      if (rsp_done) rsp_data <= dmi_rsp_data;
      if (dmireset || hardreset)      dmistat <= DMISTAT_OK;
      else if (busy_hit)              dmistat <= DMISTAT_BUSY;
      else if (rsp_done && dmi_rsp_err) dmistat <= DMISTAT_FAILED;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_client.sv
// Self-checking bench for jtag_dmi_client: decode table, directed DMI
// sequences, then randomized traffic against a transaction-level model.
module tb_jtag_dmi_client;

  localparam int          ABITS  = 16;
  localparam int          DRW    = 50;
  localparam logic [31:0] IDCODE = 32'h0000_0001;
  localparam logic [1:0]  A_NONE = 2'd0, A_CAP = 2'd1, A_SHIFT = 2'd2, A_UPD = 2'd3;
  localparam logic [49:0] M31 = 50'h0_0000_8000_0000, M49 = 50'h2_0000_0000_0000, M0 = 50'h1;

  logic              jtag_tck = 1'b0;
  logic              reset_n  = 1'b0;
  logic [4:0]        ir = '0;
  logic [1:0]        dr_action = '0;
  logic [DRW-1:0]    dr_in = '0;
  logic [DRW-1:0]    dr_out, dr_tdi_mask;
  logic              dmi_req_valid;
  logic              dmi_req_ready = 1'b0;
  logic [1:0]        dmi_req_op;
  logic [ABITS-1:0]  dmi_req_addr;
  logic [31:0]       dmi_req_data;
  logic              dmi_rsp_valid = 1'b0;
  logic [31:0]       dmi_rsp_data = '0;
  logic              dmi_rsp_err = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: phase 0 no transaction, 1 offered to DM, 2 accepted.
  int          m_phase;
  logic [1:0]  m_stat, m_op;
  logic [15:0] m_addr;
  logic [31:0] m_data, m_rsp;

  always #5 jtag_tck = ~jtag_tck;

  jtag_dmi_client #(.IDCODE(IDCODE), .ABITS(ABITS)) dut (
    .jtag_tck      (jtag_tck),
    .reset_n       (reset_n),
    .ir            (ir),
    .dr_action     (dr_action),
    .dr_in         (dr_in),
    .dr_out        (dr_out),
    .dr_tdi_mask   (dr_tdi_mask),
    .dmi_req_valid (dmi_req_valid),
    .dmi_req_ready (dmi_req_ready),
    .dmi_req_op    (dmi_req_op),
    .dmi_req_addr  (dmi_req_addr),
    .dmi_req_data  (dmi_req_data),
    .dmi_rsp_valid (dmi_rsp_valid),
    .dmi_rsp_data  (dmi_rsp_data),
    .dmi_rsp_err   (dmi_rsp_err)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive one clock's worth of inputs, let the edge happen, then return to idle.
  task automatic apply(input logic [4:0] i, input logic [1:0] a, input logic [49:0] d,
                       input logic rdy, input logic rv, input logic [31:0] rd, input logic e);
    ir = i; dr_action = a; dr_in = d;
    dmi_req_ready = rdy; dmi_rsp_valid = rv; dmi_rsp_data = rd; dmi_rsp_err = e;
    @(posedge jtag_tck);
    #1;
    dr_action = A_NONE; dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
  endtask

  task automatic peek(input logic [4:0] i, input logic [1:0] a, input logic [49:0] d);
    ir = i; dr_action = a; dr_in = d;
    #1;
  endtask

  function automatic int dr_len(input logic [4:0] i);
    case (i)
      5'h01, 5'h10: return 32;
      5'h11:        return DRW;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [63:0] model_capture(input logic [4:0] i);
    logic [1:0] st;
    st = (m_phase != 0) ? 2'd3 : m_stat;
    case (i)
      5'h01:   return 64'(IDCODE);
      5'h10:   return 64'd1 + 64'(ABITS) * 16 + 64'(m_stat) * 1024 + 64'd4096;
      5'h11:   return {14'd0, m_addr, m_rsp, st};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] model_dr_out(input logic [4:0] i, input logic [1:0] a, input logic [49:0] d);
    logic [63:0] keep;
    keep = (64'd1 << dr_len(i)) - 64'd1;
    case (a)
      A_CAP:   return model_capture(i);
      A_SHIFT: return (64'(d) >> 1) & keep;
      default: return 64'(d);
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_stat = 2'd0; m_op = 2'd0; m_addr = '0; m_data = '0; m_rsp = '0;
  endfunction

  // Advance the model across one rising edge given the inputs held over it.
  function automatic void model_step(input logic [4:0] i, input logic [1:0] a, input logic [49:0] d,
                                     input logic rdy, input logic rv, input logic [31:0] rd, input logic e);
    int next_phase;
    if (a == A_UPD && i == 5'h10 && d[17]) begin
      m_phase = 0;
      m_stat  = 2'd0;
      return;
    end
    next_phase = m_phase;
    if (m_phase == 1 && rdy) next_phase = 2;
    if (m_phase == 2 && rv) begin
      next_phase = 0;
      m_rsp = rd;
      if (e) m_stat = 2'd2;
    end
    if (a == A_UPD && i == 5'h11) begin
      if (m_phase != 0) begin
        m_stat = 2'd3;
      end else if ((d[1:0] == 2'd1 || d[1:0] == 2'd2) && m_stat == 2'd0) begin
        next_phase = 1;
        m_addr = d[49:34]; m_data = d[33:2]; m_op = d[1:0];
      end
    end
    if (a == A_UPD && i == 5'h10 && d[16]) m_stat = 2'd0;
    m_phase = next_phase;
  endfunction

  typedef struct {
    logic [4:0]  ir;
    logic [1:0]  act;
    logic [49:0] din;
    logic [49:0] exp_out;
    logic [49:0] exp_mask;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    vecs[0]  = '{5'h01, A_CAP,   50'h0,               50'h1,               M31};
    vecs[1]  = '{5'h10, A_CAP,   50'h0,               50'h1101,            M31};
    vecs[2]  = '{5'h11, A_CAP,   50'h3_FFFF_FFFF_FFFF, 50'h0,              M49};
    vecs[3]  = '{5'h1F, A_CAP,   50'h3_FFFF_FFFF_FFFF, 50'h0,              M0};
    vecs[4]  = '{5'h00, A_CAP,   50'h1,               50'h0,               M0};
    vecs[5]  = '{5'h1F, A_SHIFT, 50'h1,               50'h0,               M0};
    vecs[6]  = '{5'h1F, A_SHIFT, 50'h3_FFFF_FFFF_FFFF, 50'h1,              M0};
    vecs[7]  = '{5'h01, A_SHIFT, 50'h3_FFFF_FFFF_FFFF, 50'hFFFF_FFFF,      M31};
    vecs[8]  = '{5'h11, A_SHIFT, 50'h2_0000_0000_0003, 50'h1_0000_0000_0001, M49};
    vecs[9]  = '{5'h10, A_SHIFT, 50'h1_0000_0001_0002, 50'h8001,           M31};
    vecs[10] = '{5'h10, A_NONE,  50'h1234,            50'h1234,            M31};
    vecs[11] = '{5'h01, A_UPD,   50'h5A5A,            50'h5A5A,            M31};

    repeat (2) @(negedge jtag_tck);
    check("reset req_valid", 64'(dmi_req_valid), 64'd0);
    check("reset req_op",    64'(dmi_req_op),    64'd0);
    check("reset req_addr",  64'(dmi_req_addr),  64'd0);
    check("reset req_data",  64'(dmi_req_data),  64'd0);
    reset_n = 1'b1;

    // Decode/mux table, applied in the post-reset state.
    for (int v = 0; v < 12; v++) begin
      peek(vecs[v].ir, vecs[v].act, vecs[v].din);
      check($sformatf("vec%0d dr_out", v),  64'(dr_out),      64'(vecs[v].exp_out));
      check($sformatf("vec%0d tdi_mask", v), 64'(dr_tdi_mask), 64'(vecs[v].exp_mask));
    end
    dr_action = A_NONE;
    @(negedge jtag_tck);

    // Write request, accepted at once, then a busy update while waiting.
    apply(5'h11, A_UPD, {16'h0010, 32'hDEADBEEF, 2'd2}, 0, 0, 0, 0);
    check("wr req_valid", 64'(dmi_req_valid), 64'd1);
    check("wr req_op",    64'(dmi_req_op),    64'd2);
    check("wr req_addr",  64'(dmi_req_addr),  64'h10);
    check("wr req_data",  64'(dmi_req_data),  64'hDEADBEEF);
    apply(5'h11, A_NONE, 50'h0, 1, 0, 0, 0);
    check("wr accepted valid", 64'(dmi_req_valid), 64'd0);
    peek(5'h11, A_CAP, 50'h0);
    check("wait dmi capture", 64'(dr_out), {14'd0, 16'h0010, 32'h0, 2'd3});
    apply(5'h11, A_UPD, {16'h0020, 32'h1, 2'd1}, 0, 0, 0, 0);
    check("busy upd no req", 64'(dmi_req_valid), 64'd0);
    check("busy upd addr",   64'(dmi_req_addr),  64'h10);
    apply(5'h11, A_NONE, 50'h0, 0, 1, 32'hCAFEF00D, 0);
    peek(5'h11, A_CAP, 50'h0);
    check("sticky busy capture", 64'(dr_out), {14'd0, 16'h0010, 32'hCAFEF00D, 2'd3});
    apply(5'h10, A_UPD, 50'h10000, 0, 0, 0, 0);
    peek(5'h11, A_CAP, 50'h0);
    check("dmireset capture", 64'(dr_out), {14'd0, 16'h0010, 32'hCAFEF00D, 2'd0});

    // Read request with response data returned in the next capture.
    apply(5'h11, A_UPD, {16'h0011, 32'h0, 2'd1}, 0, 0, 0, 0);
    check("rd req_op",   64'(dmi_req_op),   64'd1);
    check("rd req_addr", 64'(dmi_req_addr), 64'h11);
    apply(5'h11, A_NONE, 50'h0, 1, 0, 0, 0);
    apply(5'h11, A_NONE, 50'h0, 0, 1, 32'h12345678, 0);
    peek(5'h11, A_CAP, 50'h0);
    check("rd capture", 64'(dr_out), {14'd0, 16'h0011, 32'h12345678, 2'd0});

    // Error response: dmistat=2 blocks the next request.
    apply(5'h11, A_UPD, {16'h0030, 32'h0, 2'd1}, 0, 0, 0, 0);
    apply(5'h11, A_NONE, 50'h0, 1, 0, 0, 0);
    apply(5'h11, A_NONE, 50'h0, 0, 1, 32'h00000BAD, 1);
    peek(5'h10, A_CAP, 50'h0);
    check("err dtmcs capture", 64'(dr_out), 64'h1901);
    apply(5'h11, A_UPD, {16'h0040, 32'h55, 2'd2}, 0, 0, 0, 0);
    check("err blocks req",  64'(dmi_req_valid), 64'd0);
    check("err blocks addr", 64'(dmi_req_addr),  64'h30);
    apply(5'h10, A_UPD, 50'h10000, 0, 0, 0, 0);

    // Hard reset on the same edge as ready; a later response is ignored.
    apply(5'h11, A_UPD, {16'h0050, 32'h1, 2'd2}, 0, 0, 0, 0);
    check("hr req_valid", 64'(dmi_req_valid), 64'd1);
    apply(5'h10, A_UPD, 50'h20000, 1, 0, 0, 0);
    check("hr drops valid", 64'(dmi_req_valid), 64'd0);
    apply(5'h11, A_NONE, 50'h0, 0, 1, 32'h77, 0);
    peek(5'h11, A_CAP, 50'h0);
    check("hr rsp ignored", 64'(dr_out), {14'd0, 16'h0050, 32'h00000BAD, 2'd0});

    // Reset asserted while a request is being offered.
    apply(5'h11, A_UPD, {16'h0060, 32'h2, 2'd1}, 0, 0, 0, 0);
    check("pre-reset valid", 64'(dmi_req_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async reset valid", 64'(dmi_req_valid), 64'd0);
    check("async reset addr",  64'(dmi_req_addr),  64'd0);
    @(negedge jtag_tck);
    reset_n = 1'b1;
    apply(5'h11, A_NONE, 50'h0, 0, 1, 32'h99, 0);
    peek(5'h11, A_CAP, 50'h0);
    check("idle rsp ignored", 64'(dr_out), 64'd0);

    // Randomized traffic against the model, starting from a fresh reset.
    dr_action = A_NONE;
    @(negedge jtag_tck);
    reset_n = 1'b0;
    @(negedge jtag_tck);
    reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge jtag_tck);
      r = $urandom_range(0, 9);
      ir = (r < 4) ? 5'h11 : (r < 7) ? 5'h10 : (r < 8) ? 5'h01 : 5'($urandom);
      dr_action     = 2'($urandom);
      dr_in         = {18'($urandom), 32'($urandom)};
      dmi_req_ready = 1'($urandom_range(0, 1));
      dmi_rsp_valid = ($urandom_range(0, 2) == 0);
      dmi_rsp_data  = $urandom;
      dmi_rsp_err   = ($urandom_range(0, 7) == 0);
      #1;
      check("rnd dr_out",   64'(dr_out),        model_dr_out(ir, dr_action, dr_in));
      check("rnd tdi_mask", 64'(dr_tdi_mask),   64'd1 << (dr_len(ir) - 1));
      check("rnd valid",    64'(dmi_req_valid), 64'(m_phase == 1));
      check("rnd op",       64'(dmi_req_op),    64'(m_op));
      check("rnd addr",     64'(dmi_req_addr),  64'(m_addr));
      check("rnd data",     64'(dmi_req_data),  64'(m_data));
      model_step(ir, dr_action, dr_in, dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
